// File: rtl/axi_r_responder_pkg.sv
// Shared types and address helper for the AXI read responder.
package axi_mem_if_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Working width for address math; callers truncate back to their own width,
    // which yields arithmetic modulo 2^ADDR_WIDTH since low bits never depend on high bits.
    localparam int NA_W = 64;

    function automatic logic [NA_W-1:0] next_addr(input logic [NA_W-1:0] addr,
                                                  input logic [2:0]      size,
                                                  input logic [7:0]      len,
                                                  input burst_t          burst);
        logic [NA_W-1:0] incr;
        logic [NA_W-1:0] wl;
        incr      = NA_W'(1) << size;
        wl        = (NA_W'(len) + NA_W'(1)) << size;
        next_addr = addr;
        case (burst)
            INCR:    next_addr = (addr & ~(incr - NA_W'(1))) + incr;
            WRAP:    next_addr = (addr & ~(wl - NA_W'(1))) | ((addr + incr) & (wl - NA_W'(1)));
            default: next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_r_responder_if.sv
// AXI AR/R slave channels plus the SRAM-style read port of the responder.
interface axi_r_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6
);
    logic                  slave_ar_valid_i;
    logic [ADDR_WIDTH-1:0] slave_ar_addr_i;
    logic [7:0]            slave_ar_len_i;
    logic [2:0]            slave_ar_size_i;
    logic [1:0]            slave_ar_burst_i;
    logic [ID_WIDTH-1:0]   slave_ar_id_i;
    logic [USER_WIDTH-1:0] slave_ar_user_i;
    logic                  slave_ar_ready_o;
    logic                  slave_r_valid_o;
    logic [DATA_WIDTH-1:0] slave_r_data_o;
    logic [1:0]            slave_r_resp_o;
    logic [USER_WIDTH-1:0] slave_r_user_o;
    logic [ID_WIDTH-1:0]   slave_r_id_o;
    logic                  slave_r_last_o;
    logic                  slave_r_ready_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_gnt_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Responder side
    modport slave (
        input  slave_ar_valid_i, slave_ar_addr_i, slave_ar_len_i, slave_ar_size_i,
               slave_ar_burst_i, slave_ar_id_i, slave_ar_user_i, slave_r_ready_i,
               mem_gnt_i, mem_rdata_i,
        output slave_ar_ready_o, slave_r_valid_o, slave_r_data_o, slave_r_resp_o,
               slave_r_user_o, slave_r_id_o, slave_r_last_o, mem_req_o, mem_addr_o
    );

    // Requester / memory side
    modport master (
        output slave_ar_valid_i, slave_ar_addr_i, slave_ar_len_i, slave_ar_size_i,
               slave_ar_burst_i, slave_ar_id_i, slave_ar_user_i, slave_r_ready_i,
               mem_gnt_i, mem_rdata_i,
        input  slave_ar_ready_o, slave_r_valid_o, slave_r_data_o, slave_r_resp_o,
               slave_r_user_o, slave_r_id_o, slave_r_last_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/axi_r_responder_buffer.sv
// Small circular FIFO holding R beats; head entry drives the R channel directly.
module axi_buffer #(
    parameter int WIDTH        = 8,
    parameter int BUFFER_DEPTH = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              push_i,
    input  logic [WIDTH-1:0]                  data_i,
    output logic                              valid_o,
    output logic [WIDTH-1:0]                  data_o,
    input  logic                              ready_i,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o & ready_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy update; the producer guarantees no push when full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i)
            wr_ptr_d = (wr_ptr_q == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push_i && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push_i && pop)
            count_d = count_q - CNT_W'(1);
    end

    // Control state; reset empties the FIFO so stale beats are never presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_r_responder.sv
// AXI read engine: walks AR bursts, reads the SRAM port one beat at a time and
// returns ordered R beats through a 3-entry buffer with credit-based issue.
module axi_r_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6
) (
    input logic              clk_i,
    input logic              rst_ni,
    axi_r_responder_if.slave bus
);
    import axi_mem_if_pkg::*;

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam int         BUF_DEPTH  = 3;
    localparam int         CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam int         BUF_W      = ID_WIDTH + USER_WIDTH + DATA_WIDTH + 2 + 1;

    state_t                state_q;
    logic                  ar_ready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    burst_t                burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [7:0]            beat_q;
    logic                  err_q;

    logic                  inflight_q, inflight_d;
    logic [ID_WIDTH-1:0]   infl_id_q, infl_id_d;
    logic [USER_WIDTH-1:0] infl_user_q, infl_user_d;
    logic                  infl_last_q, infl_last_d;

    logic [CNT_W-1:0]      buf_count;
    logic                  buf_push;
    logic [BUF_W-1:0]      buf_wdata;
    logic [BUF_W-1:0]      buf_rdata;
    logic                  buf_valid;

    logic                  ar_err;
    logic                  credit_ok;
    logic                  mem_req;
    logic                  err_push;
    logic                  issue;
    logic                  is_last;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    // Classify the incoming request; errored bursts never touch memory.
    always_comb begin
        ar_err = 1'b0;
        if (bus.slave_ar_burst_i == RSVD)
            ar_err = 1'b1;
        if (bus.slave_ar_size_i > MAX_SIZE)
            ar_err = 1'b1;
        if ((bus.slave_ar_burst_i == WRAP) &&
            !(bus.slave_ar_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
            ar_err = 1'b1;
    end

    // Issue control. Credit uses only registered state so r_ready never reaches
    // mem_req combinationally; while a request waits for gnt the credit sum can
    // only shrink, so req and addr stay stable until granted.
    always_comb begin
        credit_ok = ({1'b0, buf_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(BUF_DEPTH);
        mem_req   = (state_q == BURST) && !err_q && credit_ok;
        // Error beats wait for the in-flight beat so the buffer sees one push per cycle.
        err_push  = (state_q == BURST) && err_q && credit_ok && !inflight_q;
        issue     = (mem_req && bus.mem_gnt_i) || err_push;
        is_last   = (beat_q == len_q);
        addr_nxt  = ADDR_WIDTH'(next_addr(NA_W'(addr_q), size_q, len_q, burst_q));
    end

    // Burst FSM: latch AR in IDLE, step through beats in BURST.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= FIXED;
            id_q       <= '0;
            user_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.slave_ar_valid_i) begin
                        addr_q     <= bus.slave_ar_addr_i;
                        len_q      <= bus.slave_ar_len_i;
                        size_q     <= bus.slave_ar_size_i;
                        burst_q    <= burst_t'(bus.slave_ar_burst_i);
                        id_q       <= bus.slave_ar_id_i;
                        user_q     <= bus.slave_ar_user_i;
                        beat_q     <= '0;
                        err_q      <= ar_err;
                        ar_ready_q <= 1'b0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        if (is_last) begin
                            state_q    <= IDLE;
                            ar_ready_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_nxt;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ar_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Tag of the granted beat travels with it until the read data returns.
    always_comb begin
        inflight_d  = mem_req & bus.mem_gnt_i;
        infl_id_d   = infl_id_q;
        infl_user_d = infl_user_q;
        infl_last_d = infl_last_q;
        if (inflight_d) begin
            infl_id_d   = id_q;
            infl_user_d = user_q;
            infl_last_d = is_last;
        end
    end

    // In-flight registers; reset drops any outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q  <= 1'b0;
            infl_id_q   <= '0;
            infl_user_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            infl_id_q   <= infl_id_d;
            infl_user_q <= infl_user_d;
            infl_last_q <= infl_last_d;
        end
    end

    // Buffer entry: returned memory data, or a zero SLVERR beat for bad bursts.
    always_comb begin
        buf_push = inflight_q | err_push;
        if (inflight_q)
            buf_wdata = {infl_id_q, infl_user_q, bus.mem_rdata_i, RESP_OKAY, infl_last_q};
        else
            buf_wdata = {id_q, user_q, {DATA_WIDTH{1'b0}}, RESP_SLVERR, is_last};
    end

    axi_buffer #(
        .WIDTH        (BUF_W),
        .BUFFER_DEPTH (BUF_DEPTH)
    ) u_rbuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (buf_push),
        .data_i  (buf_wdata),
        .valid_o (buf_valid),
        .data_o  (buf_rdata),
        .ready_i (bus.slave_r_ready_i),
        .count_o (buf_count)
    );

    assign bus.slave_ar_ready_o = ar_ready_q;
    assign bus.mem_req_o        = mem_req;
    assign bus.mem_addr_o       = addr_q;
    assign bus.slave_r_valid_o  = buf_valid;
    assign {bus.slave_r_id_o, bus.slave_r_user_o, bus.slave_r_data_o,
            bus.slave_r_resp_o, bus.slave_r_last_o} = buf_rdata;

endmodule
